lfsr_stream_gen: RTL and testbench



---
 rtl/lfsr_pkg.sv | 55 +++++
 rtl/lfsr_core.sv | 47 ++++
 rtl/lfsr_stream_gen.sv | 165 ++++++++++++++++
 tb/tb_lfsr_stream_gen.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - tap tables, single-step LFSR function and FSM encoding for lfsr_stream_gen
package lfsr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } fsm_e;

  // Primitive polynomials: x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1,
  // x^32+x^22+x^2+x+1, x^64+x^63+x^61+x^60+1.
  localparam logic [63:0] FIB_TAPS_8     = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] FIB_TAPS_16    = 64'h0000_0000_0000_B400;
  localparam logic [63:0] FIB_TAPS_32    = 64'h0000_0000_8020_0003;
  localparam logic [63:0] FIB_TAPS_64    = 64'hD800_0000_0000_0000;
  localparam logic [63:0] GALOIS_TAPS_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] GALOIS_TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] GALOIS_TAPS_32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] GALOIS_TAPS_64 = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] fib_taps(input int len);
    case (len)
      8:       return FIB_TAPS_8;
      16:      return FIB_TAPS_16;
      32:      return FIB_TAPS_32;
      64:      return FIB_TAPS_64;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] galois_taps(input int len);
    case (len)
      8:       return GALOIS_TAPS_8;
      16:      return GALOIS_TAPS_16;
      32:      return GALOIS_TAPS_32;
      64:      return GALOIS_TAPS_64;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] len_mask(input int len);
    return (len >= 64) ? {64{1'b1}} : ((64'd1 << len) - 64'd1);
  endfunction

  // mode 0 = Fibonacci (shift left), mode 1 = Galois (shift right).
  function automatic logic [63:0] lfsr_step(input logic [63:0] state, input logic mode,
                                            input int len);
    logic [63:0] s;
    s = state & len_mask(len);
    if (!mode) begin
      return ((s << 1) | {63'd0, ^(s & fib_taps(len))}) & len_mask(len);
    end
    return (s >> 1) ^ (s[0] ? galois_taps(len) : 64'd0);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - registered LFSR state with load and STEPS-shift advance
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int                  LFSR_LEN = 32,
  parameter int                  STEPS    = 1,
  parameter int                  MODE     = 0,
  parameter logic [LFSR_LEN-1:0] SEED     = {{(LFSR_LEN-1){1'b0}}, 1'b1}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [LFSR_LEN-1:0] load_val,
  input  logic                advance,
  output logic [LFSR_LEN-1:0] state
);

  logic [LFSR_LEN-1:0] state_q, state_d;
  logic [LFSR_LEN-1:0] adv_val;

  always_comb begin
    adv_val = state_q;
    for (int i = 0; i < STEPS; i++) begin
      adv_val = LFSR_LEN'(lfsr_step(64'(adv_val), MODE != 0, LFSR_LEN));
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (advance) begin
      state_d = adv_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_stream_gen.sv
// rtl/lfsr_stream_gen.sv - PRBS burst source on a valid/ready stream
// Optional loop-back checker LFSR and err_cnt enabled by LFSR_CHECK_EN.
module lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter int          LFSR_LEN = 32,
  parameter int          WIDTH    = 32,
  parameter int          STEPS    = 1,
  parameter int          MODE     = 0,
  parameter logic [63:0] SEED     = 64'd1,
  parameter int          LEN_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                seed_load,
  input  logic [LFSR_LEN-1:0] seed_val,
  input  logic                start,
  input  logic [LEN_W-1:0]    burst_len,
  output logic                busy,
  output logic                seed_err,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WIDTH-1:0]    m_data,
  output logic                m_last,
  input  logic                s_valid,
  input  logic [WIDTH-1:0]    s_data,
  output logic [15:0]         err_cnt
);

  if (!(LFSR_LEN == 8 || LFSR_LEN == 16 || LFSR_LEN == 32 || LFSR_LEN == 64)) begin : g_bad_len
    $error("lfsr_stream_gen: LFSR_LEN %0d has no tap table entry", LFSR_LEN);
  end
  if (WIDTH > LFSR_LEN) begin : g_bad_width
    $error("lfsr_stream_gen: WIDTH %0d exceeds LFSR_LEN %0d", WIDTH, LFSR_LEN);
  end
  if (STEPS < 1 || STEPS > LFSR_LEN) begin : g_bad_steps
    $error("lfsr_stream_gen: STEPS %0d out of range", STEPS);
  end
  if (SEED[LFSR_LEN-1:0] == '0) begin : g_bad_seed
    $error("lfsr_stream_gen: SEED must be nonzero");
  end

  fsm_e                fsm_q, fsm_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                seed_err_q, seed_err_d;
  logic                handshake;
  logic                seed_take;
  logic                seed_zero;
  logic [LFSR_LEN-1:0] seed_eff;
  logic [LFSR_LEN-1:0] gen_state;
  logic                unused_gen_bits;

  assign handshake = m_valid & m_ready;
  assign seed_take = seed_load & (fsm_q == IDLE);
  assign seed_zero = (seed_val == '0);
  // A zero seed would lock the LFSR, so it is replaced by 1 and flagged.
  assign seed_eff  = seed_zero ? {{(LFSR_LEN-1){1'b0}}, 1'b1} : seed_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      cnt_q      <= '0;
      seed_err_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      seed_err_q <= seed_err_d;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    seed_err_d = seed_err_q | (seed_take & seed_zero);
    case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d = BURST;
          cnt_d = burst_len;
        end
      end
      BURST: begin
        if (handshake) begin
          if (cnt_q == '0) begin
            fsm_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (fsm_q == BURST);
    m_valid = (fsm_q == BURST);
    m_last  = (fsm_q == BURST) && (cnt_q == '0);
  end

  assign seed_err = seed_err_q;

  lfsr_core #(
    .LFSR_LEN (LFSR_LEN),
    .STEPS    (STEPS),
    .MODE     (MODE),
    .SEED     (SEED[LFSR_LEN-1:0])
  ) u_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_take),
    .load_val (seed_eff),
    .advance  (handshake),
    .state    (gen_state)
  );

  assign m_data          = gen_state[WIDTH-1:0];
  assign unused_gen_bits = ^gen_state;

`ifdef LFSR_CHECK_EN
  logic [LFSR_LEN-1:0] chk_state;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                chk_mismatch;
  logic                unused_chk_bits;

  lfsr_core #(
    .LFSR_LEN (LFSR_LEN),
    .STEPS    (STEPS),
    .MODE     (MODE),
    .SEED     (SEED[LFSR_LEN-1:0])
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_take),
    .load_val (seed_eff),
    .advance  (s_valid),
    .state    (chk_state)
  );

  assign chk_mismatch    = s_valid && (s_data != chk_state[WIDTH-1:0]);
  assign unused_chk_bits = ^chk_state;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (chk_mismatch && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_chk_inputs;
  assign unused_chk_inputs = ^{s_valid, s_data};
  assign err_cnt           = 16'd0;
`endif

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// tb/tb_lfsr_stream_gen.sv - randomized bench with behavioural PRBS/burst model for lfsr_stream_gen
module tb_lfsr_stream_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_load = 1'b0;
  logic [7:0]  seed_val = 8'd0;
  logic        start = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic        busy;
  logic        seed_err;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_last;
  logic        s_valid;
  logic [7:0]  s_data;
  logic [15:0] err_cnt;

  logic        loop_en = 1'b0;
  logic        rnd_s_valid = 1'b0;
  logic [7:0]  rnd_s_data = 8'd0;
  int          flip_at = -1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_stream_gen #(
    .LFSR_LEN (8),
    .WIDTH    (8),
    .STEPS    (1),
    .MODE     (0),
    .SEED     (64'h1),
    .LEN_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .seed_err  (seed_err),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .err_cnt   (err_cnt)
  );

  // Behavioural model state.
  logic [7:0] mdl_state = 8'h01;
  logic [7:0] mdl_chk = 8'h01;
  bit         mdl_active = 0;
  bit         mdl_seed_err = 0;
  bit         mdl_init = 0;
  int         mdl_left = 0;
  int         mdl_err = 0;
  int         beat_idx = 0;

  assign s_valid = loop_en ? (m_valid & m_ready) : rnd_s_valid;
  assign s_data  = loop_en ? (m_data ^ ((beat_idx == flip_at) ? 8'h04 : 8'h00)) : rnd_s_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1: new bit 0 is the parity of state bits 7,5,4,3.
  function automatic logic [7:0] prbs_next(input logic [7:0] s);
    int fb;
    fb = $countones(s & 8'hB8) % 2;
    return 8'((int'(s) * 2 + fb) % 256);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl_state    = 8'h01;
      mdl_chk      = 8'h01;
      mdl_active   = 0;
      mdl_seed_err = 0;
      mdl_left     = 0;
      mdl_err      = 0;
      mdl_init     = 1;
    end else begin
`ifdef LFSR_CHECK_EN
      if (s_valid && s_data != mdl_chk && mdl_err < 65535) mdl_err++;
      if (!mdl_active && seed_load) mdl_chk = (seed_val == 8'd0) ? 8'h01 : seed_val;
      else if (s_valid) mdl_chk = prbs_next(mdl_chk);
`endif
      if (!mdl_active) begin
        if (seed_load) begin
          mdl_state = (seed_val == 8'd0) ? 8'h01 : seed_val;
          if (seed_val == 8'd0) mdl_seed_err = 1;
        end
        if (start) begin
          mdl_active = 1;
          mdl_left   = int'(burst_len) + 1;
        end
      end else if (m_ready) begin
        mdl_state = prbs_next(mdl_state);
        beat_idx++;
        mdl_left--;
        if (mdl_left == 0) mdl_active = 0;
      end
    end
  end

  // Per-cycle comparison plus handshake capture, away from the active edge.
  logic [8:0] hs_q[$];
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    if (mdl_init) begin
      check("m_valid", m_valid, mdl_active);
      check("busy", busy, mdl_active);
      check("m_last", m_last, mdl_active && mdl_left == 1);
      check("m_data", m_data, mdl_state);
      check("seed_err", seed_err, mdl_seed_err);
      check("err_cnt", err_cnt, 64'(mdl_err));
      if (prev_stall) begin
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) hs_q.push_back({m_last, m_data});
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check("burst_timeout", busy, 0);
  endtask

  task automatic run_burst(input int bl, input int budget);
    burst_len = 8'(bl);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(budget);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] exp1[6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
  logic [7:0] exp4[4] = '{8'hA5, 8'h4A, 8'h95, 8'h2A};
  bit         seen[256];
  int         distinct;
  bit         zero_seen;
  logic [1:0] rdy_pat = 2'b00;

  initial begin
    #1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_m_data", m_data, 8'h01);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_m_last", m_last, 0);
    check("rst_seed_err", seed_err, 0);
    check("rst_err_cnt", err_cnt, 0);

    // Six-beat burst from seed 1.
    m_ready = 1'b1;
    hs_q.delete();
    run_burst(5, 40);
    check("t1_count", hs_q.size(), 6);
    for (int i = 0; i < 6 && i < hs_q.size(); i++) begin
      check("t1_data", hs_q[i][7:0], exp1[i]);
      check("t1_last", hs_q[i][8], i == 5);
    end

    // Full period.
    do_reset();
    hs_q.delete();
    run_burst(254, 400);
    distinct  = 0;
    zero_seen = 0;
    foreach (hs_q[i]) begin
      if (hs_q[i][7:0] == 8'd0) zero_seen = 1;
      if (!seen[hs_q[i][7:0]]) begin
        seen[hs_q[i][7:0]] = 1;
        distinct++;
      end
    end
    check("t2_beats", hs_q.size(), 255);
    check("t2_distinct", distinct, 255);
    check("t2_zero_seen", zero_seen, 0);
    check("t2_wrap", m_data, 8'h01);

    // Stalled burst of 4 with ready pattern 1,0,0,1.
    do_reset();
    hs_q.delete();
    burst_len = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60 && busy; i++) begin
      m_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    check("t3_timeout", busy, 0);
    check("t3_count", hs_q.size(), 4);
    for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
      check("t3_data", hs_q[i][7:0], exp1[i]);
      check("t3_last", hs_q[i][8], i == 3);
    end

    // Seed handling.
    m_ready = 1'b1;
    seed_load = 1'b1;
    seed_val = 8'h00;
    tick();
    seed_load = 1'b0;
    check("t4_zero_seed_state", m_data, 8'h01);
    check("t4_zero_seed_err", seed_err, 1);
    hs_q.delete();
    seed_load = 1'b1;
    seed_val = 8'hA5;
    burst_len = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    seed_val = 8'h5A;
    tick();
    seed_load = 1'b0;
    wait_idle(40);
    check("t4_count", hs_q.size(), 4);
    for (int i = 0; i < 4 && i < hs_q.size(); i++) check("t4_data", hs_q[i][7:0], exp4[i]);
    check("t4_err_sticky", seed_err, 1);
    do_reset();
    check("t4_err_cleared", seed_err, 0);

    // Reset on the third beat of an 8-beat burst.
    burst_len = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t5_third_beat", m_data, 8'h04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_m_valid", m_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_m_data", m_data, 8'h01);
    hs_q.delete();
    run_burst(1, 20);
    check("t5_restart", (hs_q.size() > 0) ? hs_q[0][7:0] : 8'hxx, 8'h01);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      m_ready     = ($urandom % 4) != 0;
      start       = ($urandom % 6) == 0;
      burst_len   = 8'($urandom_range(0, 12));
      seed_load   = ($urandom % 25) == 0;
      seed_val    = (($urandom % 3) == 0) ? 8'h00 : 8'($urandom);
      rnd_s_valid = ($urandom % 3) == 0;
      rnd_s_data  = 8'($urandom);
      tick();
    end
    start = 1'b0;
    seed_load = 1'b0;
    rnd_s_valid = 1'b0;
    m_ready = 1'b1;
    wait_idle(40);

    // Loop-back: 1000 clean beats, then one corrupted beat.
    do_reset();
    loop_en = 1'b1;
    for (int b = 0; b < 4; b++) run_burst(249, 400);
    check("t6_clean_err_cnt", err_cnt, 0);
    flip_at = beat_idx + 10;
    run_burst(19, 60);
`ifdef LFSR_CHECK_EN
    check("t6_flip_err_cnt", err_cnt, 1);
`else
    check("t6_flip_err_cnt", err_cnt, 0);
`endif
    loop_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
